// File: rtl/player_link_pkg.sv
// Shared definitions for the two-board player link (rx today, tx later).
// Holds the frame constants, the decoded player state record, the receive
// FSM state type and the payload pack/unpack helpers so both ends agree on
// field positions.
//
// Payload vector convention: {B1, B2, B3, B4, B5, B6}, B1 in bits [47:40].
package player_link_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         FRAME_LEN = 8;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [3:0]  hp;
      logic [3:0]  aggro;
      logic        flip_h;
      logic [1:0]  pclass;
      logic        game_start;
      logic [6:0]  boss_hp;
   } player_state_t;

   typedef enum logic {
      HUNT    = 1'b0,
      PAYLOAD = 1'b1
   } rx_state_t;

   // B5[3:0] and B6[7] are reserved zero bits; they are not part of the
   // decoded state and are checked by the receiver before accepting.
   function automatic player_state_t unpack_payload(input logic [47:0] p);
      player_state_t s;
      s.x          = {p[47:40], p[39:36]};
      s.y          = {p[35:32], p[31:24]};
      s.hp         = p[23:20];
      s.aggro      = p[19:16];
      s.flip_h     = p[15];
      s.pclass     = p[14:13];
      s.game_start = p[12];
      s.boss_hp    = p[6:0];
      return s;
   endfunction

   function automatic logic [47:0] pack_payload(input player_state_t s);
      return {s.x, s.y, s.hp, s.aggro, s.flip_h, s.pclass, s.game_start,
              4'b0000, 1'b0, s.boss_hp};
   endfunction

endpackage

// File: rtl/player_link_rx.sv
// Receive-side frame decoder for the two-board link.
// Parses fixed 8-byte frames (sync, 6 payload bytes, XOR checksum) from the
// UART byte stream and presents the peer's state as registered outputs that
// only ever change atomically on an accepted frame.
//
// Ports:
//   clk                 system/pixel clock
//   rst                 asynchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   player_2_*          peer position/hp/aggro/flip/class
//   player2_game_start  peer game-start flag
//   boss_out_hp         boss hp reported by the peer
//   player_2_data_valid link alive (a good frame within TIMEOUT_CYCLES)
//   frame_strobe        one-cycle pulse per accepted frame
//   err_cnt             saturating count of rejected/abandoned frames
//
// state   | meaning
// HUNT    | discarding bytes until the sync byte
// PAYLOAD | collecting B1..B7, idx_q is the index of the next byte
module player_link_rx
   import player_link_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 6_500_000,
   parameter int GAP_CYCLES     = 65_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] player_2_x,
   output logic [11:0] player_2_y,
   output logic [3:0]  player_2_hp,
   output logic [3:0]  player_2_aggro,
   output logic        player_2_flip_h,
   output logic [1:0]  player_2_class,
   output logic        player2_game_start,
   output logic [6:0]  boss_out_hp,
   output logic        player_2_data_valid,
   output logic        frame_strobe,
   output logic [7:0]  err_cnt
);

   localparam int LINK_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

   localparam logic [LINK_W-1:0] LINK_TC  = LINK_W'(TIMEOUT_CYCLES);
   localparam logic [LINK_W-1:0] LINK_ONE = LINK_W'(1);
   // Abort on the idle cycle that brings the idle count up to GAP_CYCLES.
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

   rx_state_t         st_q, st_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [6:1][7:0]   shadow_q, shadow_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [LINK_W-1:0] link_q, link_d;
   player_state_t     out_q, out_d;
   logic              valid_q, valid_d;
   logic              strobe_q, strobe_d;
   logic [7:0]        err_q, err_d;
   logic              accept, reject;

   always_comb begin
      st_d     = st_q;
      idx_d    = idx_q;
      csum_d   = csum_q;
      shadow_d = shadow_q;
      gap_d    = gap_q;
      accept   = 1'b0;
      reject   = 1'b0;

      case (st_q)
         HUNT: begin
            idx_d  = 3'd1;
            csum_d = 8'h00;
            gap_d  = '0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               st_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (rx_valid) begin
               // A byte in the expiry cycle still counts; no abort.
               gap_d = '0;
               if (idx_q == 3'd7) begin
                  st_d = HUNT;
                  if ((csum_q == rx_data) && (shadow_q[5][3:0] == 4'h0) &&
                      !shadow_q[6][7]) begin
                     accept = 1'b1;
                  end else begin
                     reject = 1'b1;
                  end
               end else begin
                  shadow_d[idx_q] = rx_data;
                  csum_d          = csum_q ^ rx_data;
                  idx_d           = idx_q + 3'd1;
               end
            end else if (gap_q == GAP_LAST) begin
               st_d   = HUNT;
               reject = 1'b1;
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end
         default: st_d = HUNT;
      endcase
   end

   always_comb begin
      out_d    = out_q;
      valid_d  = valid_q;
      strobe_d = accept;
      err_d    = err_q;
      link_d   = link_q;

      if (accept) begin
         out_d  = unpack_payload({shadow_q[1], shadow_q[2], shadow_q[3],
                                  shadow_q[4], shadow_q[5], shadow_q[6]});
         link_d = '0;
      end else if (link_q != LINK_TC) begin
         link_d = link_q + LINK_ONE;
      end

      // Accept wins over a coincident timeout because link_d is 0 then.
      if (accept) begin
         valid_d = 1'b1;
      end else if (link_d == LINK_TC) begin
         valid_d = 1'b0;
      end

      if (reject && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q     <= HUNT;
         idx_q    <= 3'd1;
         csum_q   <= 8'h00;
         shadow_q <= '0;
         gap_q    <= '0;
         link_q   <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
         err_q    <= 8'h00;
      end else begin
         st_q     <= st_d;
         idx_q    <= idx_d;
         csum_q   <= csum_d;
         shadow_q <= shadow_d;
         gap_q    <= gap_d;
         link_q   <= link_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   assign player_2_x          = out_q.x;
   assign player_2_y          = out_q.y;
   assign player_2_hp         = out_q.hp;
   assign player_2_aggro      = out_q.aggro;
   assign player_2_flip_h     = out_q.flip_h;
   assign player_2_class      = out_q.pclass;
   assign player2_game_start  = out_q.game_start;
   assign boss_out_hp         = out_q.boss_hp;
   assign player_2_data_valid = valid_q;
   assign frame_strobe        = strobe_q;
   assign err_cnt             = err_q;

endmodule
